// File: rtl/serial_magnitude_comparator_if.sv
// Stream and status signals of the bit-serial magnitude comparator.
// The master side drives operands and start; the slave side is the comparator.
interface serial_magnitude_comparator_if;
  logic start;
  logic in_valid;
  logic in_ready;
  logic a_bit;
  logic b_bit;
  logic busy;
  logic decided;
  logic done;
  logic L;
  logic E;
  logic G;

  modport master (
    output start, in_valid, a_bit, b_bit,
    input  in_ready, busy, decided, done, L, E, G
  );

  modport slave (
    input  start, in_valid, a_bit, b_bit,
    output in_ready, busy, decided, done, L, E, G
  );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial MSB-first magnitude comparator: consumes WIDTH bit pairs over a
// valid/ready stream and presents held L/E/G flags with a one-cycle done pulse.
module serial_magnitude_comparator #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  serial_magnitude_comparator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    FINISH  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REL_EQ = 2'd0,
    REL_LT = 2'd1,
    REL_GT = 2'd2
  } rel_t;

  state_t             state_q, state_d;
  rel_t               rel_q, rel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               decided_q, decided_d;
  logic               l_q, l_d;
  logic               e_q, e_d;
  logic               g_q, g_d;
  logic               in_ready;
  logic               beat;

  assign in_ready = (state_q == COMPARE);
  assign beat     = bus.in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rel_q     <= REL_EQ;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      l_q       <= 1'b0;
      e_q       <= 1'b0;
      g_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      rel_q     <= rel_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      l_q       <= l_d;
      e_q       <= e_d;
      g_q       <= g_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rel_d     = rel_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    l_d       = l_q;
    e_d       = e_q;
    g_d       = g_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = COMPARE;
          cnt_d     = '0;
          rel_d     = REL_EQ;
          decided_d = 1'b0;
        end
      end
      COMPARE: begin
        if (beat) begin
          cnt_d = cnt_q + 1'b1;
          // First differing pair decides; later pairs are consumed only.
          if (rel_q == REL_EQ && bus.a_bit != bus.b_bit) begin
            rel_d     = bus.a_bit ? REL_GT : REL_LT;
            decided_d = 1'b1;
          end
          // Flags load on the last beat so they are valid alongside done.
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = FINISH;
            l_d     = (rel_d == REL_LT);
            e_d     = (rel_d == REL_EQ);
            g_d     = (rel_d == REL_GT);
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready = in_ready;
  assign bus.busy     = in_ready;
  assign bus.done     = (state_q == FINISH);
  assign bus.decided  = decided_q;
  assign bus.L        = l_q;
  assign bus.E        = e_q;
  assign bus.G        = g_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed table-driven bench for the bit-serial magnitude comparator.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_serial_magnitude_comparator;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   done_cnt;
  logic [2:0] last_leg;

  serial_magnitude_comparator_if intf ();

  serial_magnitude_comparator #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (intf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (intf.done === 1'b1) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    bit         stall;
    int         start_at;
    int         decide_beat;
    logic [2:0] leg;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] model_leg(input logic [7:0] a, input logic [7:0] b);
    if (a < b)       return 3'b100;
    else if (a == b) return 3'b010;
    else             return 3'b001;
  endfunction

  function automatic int model_first_diff(input logic [7:0] a, input logic [7:0] b);
    for (int k = 0; k < 8; k++)
      if (a[7-k] != b[7-k]) return k + 1;
    return 0;
  endfunction

  // Starts in IDLE aligned #1 after an edge; returns in the IDLE cycle after FINISH.
  task automatic run_cmp(input logic [7:0] a, input logic [7:0] b, input bit stall,
                         input int start_at, input int decide_beat,
                         input logic [2:0] exp_leg, input string tag);
    int i;
    int cyc;
    int dc0;
    bit v;
    i   = 0;
    cyc = 0;
    dc0 = done_cnt;
    intf.start = 1'b1;
    @(posedge clk); #1;
    intf.start = 1'b0;
    chk({tag, " busy"}, intf.busy, 1);
    chk({tag, " in_ready"}, intf.in_ready, 1);
    while (i < 8 && cyc < 100) begin
      v = stall ? (cyc % 3 == 0) : 1'b1;
      intf.in_valid = v;
      intf.a_bit    = v ? a[7-i] : ~a[7-i];
      intf.b_bit    = v ? b[7-i] : ~b[7-i];
      intf.start    = (start_at != 0 && i == start_at - 1 && v);
      @(posedge clk); #1;
      cyc++;
      intf.start = 1'b0;
      if (v) begin
        i++;
        chk($sformatf("%s decided@%0d", tag, i), intf.decided,
            (decide_beat != 0 && i >= decide_beat) ? 1 : 0);
      end
      if (i < 8) begin
        chk($sformatf("%s no_done@%0d", tag, cyc), intf.done, 0);
        chk($sformatf("%s hold@%0d", tag, cyc), {intf.L, intf.E, intf.G}, last_leg);
      end
    end
    if (i < 8) chk({tag, " timeout beats"}, i, 8);
    intf.in_valid = 1'b0;
    chk({tag, " done"}, intf.done, 1);
    chk({tag, " LEG"}, {intf.L, intf.E, intf.G}, exp_leg);
    chk({tag, " finish in_ready"}, intf.in_ready, 0);
    chk({tag, " finish busy"}, intf.busy, 0);
    last_leg = exp_leg;
    @(posedge clk); #1;
    chk({tag, " done pulse"}, intf.done, 0);
    chk({tag, " LEG held"}, {intf.L, intf.E, intf.G}, exp_leg);
    chk({tag, " idle busy"}, intf.busy, 0);
    chk({tag, " idle in_ready"}, intf.in_ready, 0);
    chk({tag, " done count"}, done_cnt - dc0, 1);
    chk({tag, " decided final"}, intf.decided, (decide_beat != 0) ? 1 : 0);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    int dc0;
    errors   = 0;
    checks   = 0;
    done_cnt = 0;
    last_leg = 3'b000;

    vecs[0] = '{8'b11000011, 8'b11001011, 1'b0, 0, 5, 3'b100};
    vecs[1] = '{8'b01001011, 8'b01001011, 1'b0, 0, 0, 3'b010};
    vecs[2] = '{8'b11111111, 8'b00000000, 1'b0, 0, 1, 3'b001};
    vecs[3] = '{8'b00000010, 8'b01111111, 1'b0, 0, 2, 3'b100};
    vecs[4] = '{8'b01011111, 8'b10000000, 1'b1, 0, 1, 3'b100};
    vecs[5] = '{8'b10000000, 8'b01111111, 1'b1, 0, 1, 3'b001};
    vecs[6] = '{8'b00000001, 8'b00000000, 1'b0, 0, 8, 3'b001};
    vecs[7] = '{8'b00000000, 8'b00000001, 1'b1, 0, 8, 3'b100};
    vecs[8] = '{8'b10100000, 8'b10011111, 1'b0, 3, 3, 3'b001};

    intf.start    = 1'b0;
    intf.in_valid = 1'b0;
    intf.a_bit    = 1'b0;
    intf.b_bit    = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", {intf.in_ready, intf.busy, intf.decided, intf.done,
                          intf.L, intf.E, intf.G}, 7'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int n = 0; n < 9; n++)
      run_cmp(vecs[n].a, vecs[n].b, vecs[n].stall, vecs[n].start_at,
              vecs[n].decide_beat, vecs[n].leg, $sformatf("vec%0d", n));

    // Junk beats while IDLE must not be consumed nor disturb the held result.
    for (int k = 0; k < 4; k++) begin
      intf.in_valid = 1'b1;
      intf.a_bit    = k[0];
      intf.b_bit    = ~k[0];
      @(posedge clk); #1;
      chk($sformatf("idle junk LEG%0d", k), {intf.L, intf.E, intf.G}, last_leg);
      chk($sformatf("idle junk ready%0d", k), intf.in_ready, 0);
    end
    intf.in_valid = 1'b0;
    run_cmp(8'b00110011, 8'b00110011, 1'b0, 0, 0, 3'b010, "after_junk");

    // Asynchronous reset between edges after beat 4 discards the comparison.
    dc0 = done_cnt;
    ra = 8'b11100000;
    rb = 8'b10000011;
    intf.start = 1'b1;
    @(posedge clk); #1;
    intf.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      intf.in_valid = 1'b1;
      intf.a_bit    = ra[7-k];
      intf.b_bit    = rb[7-k];
      @(posedge clk); #1;
    end
    chk("pre-reset decided", intf.decided, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset outputs", {intf.in_ready, intf.busy, intf.decided, intf.done,
                                intf.L, intf.E, intf.G}, 7'b0);
    intf.in_valid = 1'b0;
    last_leg = 3'b000;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset no done", done_cnt - dc0, 0);
    run_cmp(ra, rb, 1'b0, 0, 2, 3'b001, "post_reset");

    // Back-to-back with start in the first IDLE cycle after each FINISH.
    for (int r = 0; r < 5; r++) begin
      ra = 8'($urandom);
      rb = (r == 2) ? ra : 8'($urandom);
      run_cmp(ra, rb, 1'b0, 0, model_first_diff(ra, rb), model_leg(ra, rb),
              $sformatf("b2b%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
Bit-serial counterpart of the team's parallel 8-bit comparator. Two operands arrive one bit pair per beat, MSB first, over a valid/ready stream. After WIDTH beats the block presents registered L/E/G flags with a one-cycle done pulse. Used where operands are delivered serially, for example from a shift-register link, instead of as parallel words.

Parameters:
WIDTH, 8, operand width in bits (number of beats per comparison); legal range 2..32
CNT_W, $clog2(WIDTH+1), beat counter width (derived; do not override)

Ports:
clk  input  1  single system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a new comparison
in_valid  input  1  a_bit/b_bit hold a valid bit pair
in_ready  output  1  block accepts a bit pair this cycle
a_bit  input  1  current bit of operand A (MSB first)
b_bit  input  1  current bit of operand B (MSB first)
busy  output  1  comparison in progress
decided  output  1  a differing bit pair has already been seen in the current comparison
done  output  1  one-cycle pulse: L/E/G updated with a new result
L  output  1  A < B (held)
E  output  1  A == B (held)
G  output  1  A > B (held)

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values: in_ready=0, busy=0, decided=0, done=0, L=0, E=0, G=0. FSM goes to IDLE and the beat counter goes to 0.
- FSM states:
  - IDLE to COMPARE on start=1.
  - COMPARE to FINISH when the WIDTH-th beat is accepted.
  - FINISH to IDLE unconditionally, after one cycle.
- IDLE:
  - in_ready=0, busy=0.
  - On start: counter=0, internal relation set to EQUAL, decided=0.
  - L/E/G keep the previous result.
- COMPARE:
  - busy=1, in_ready=1.
  - A beat is accepted when in_valid && in_ready. Cycles with in_valid=0 change nothing, and there is no timeout.
  - Per accepted beat, while the relation is EQUAL:
    - a_bit=1, b_bit=0: relation becomes GREATER and decided=1.
    - a_bit=0, b_bit=1: relation becomes LESS and decided=1.
    - Equal bits: relation stays EQUAL.
  - Once decided=1, later bits are still consumed (counter advances) but do not change the relation.
  - Counter increments per accepted beat. The beat that makes counter==WIDTH-1 before increment is the last beat.
- FINISH (the cycle after the last beat is accepted):
  - done=1 for exactly this cycle.
  - L/E/G are registered from the relation; exactly one of them is 1.
  - in_ready=0, busy=0.
- Latency: done asserts 1 cycle after the last accepted beat. Minimum comparison time is start + WIDTH beats + 1 = WIDTH+2 cycles.
- Result hold: L/E/G stay unchanged until the next FINISH. They are not cleared by start. decided stays at its final value until the next start.
- start while in COMPARE or FINISH is ignored; no restart, no abort.
- start in the cycle after FINISH (IDLE) is accepted normally, so back-to-back comparisons have a one-cycle gap minimum.
- in_valid in IDLE or FINISH is ignored; no beat is consumed.
- rst_n low mid-comparison: immediate return to reset values, and the partial result is discarded.
- No width growth: internal state is a 2-bit relation plus a CNT_W-bit counter. Operands are never stored.

Test Plan:
- Basic: reset, start, stream A=11000011 / B=11001011 MSB first, in_valid held 1. Required: decided rises after the 5th beat, done pulses 1 cycle after the 8th beat with L=1 E=0 G=0, busy=0 afterwards.
- Equal and extremes: A=B=01001011 gives E=1, decided=0. A=11111111 / B=00000000 gives G=1, with decided=1 after the 1st beat. A=00000010 / B=01111111 gives L=1.
- Stalls: A=01011111 / B=10000000 with in_valid toggled 1,0,0,1,... Required: exactly 8 accepted beats, bits during in_valid=0 ignored, L=1, done once. Check that in_ready=0 in IDLE/FINISH.
- Protocol abuse: start pulsed during COMPARE at beat 3 gives no restart and the result matches the uninterrupted operands. in_valid=1 with junk bits while IDLE leaves L/E/G unchanged.
- Reset mid-op: assert rst_n=0 asynchronously (not on an edge) after beat 4. Required: all outputs reach reset values immediately, no done pulse. Then a new comparison A=11100000 / B=10000011 gives G=1.
- Back-to-back: run 5 random operand pairs with start issued in the first IDLE cycle after each FINISH. Compare each result against a $signed-free A<B / A==B / A>B reference model, and confirm that L/E/G hold between done pulses.
